fft_seq_ctrl: RTL



---
 rtl/fft_seq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fft_seq_ctrl.sv
// Sequencer for a 32-point pipelined FFT: gates stage advance, pads short frames with zeros,
// flushes the pipeline, and counts output frames. Define FFT_SEQ_STATS_EN to build the frame counter.
module fft_seq_ctrl #(
   parameter int DRAIN_CYC = 31,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             last_i,
   input  logic             out_valid_i,
   output logic             pipe_en_o,
   output logic             zero_ins_o,
   output logic             state_o,
   output logic [3:0]       wn_idx_o,
   output logic             frame_start_o,
   output logic             frame_done_o,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic             busy_o,
   output logic [1:0]       err_o
);

   localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

   typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [4:0]     scnt, scnt_nxt;
   logic [DW-1:0]  dcnt, dcnt_nxt;
   logic [1:0]     err, err_nxt;
   logic [4:0]     ocnt;
   logic           done_p1;
   logic           pipe_en, zero_ins;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         scnt  <= '0;
         dcnt  <= '0;
         err   <= '0;
      end else begin
         state <= state_nxt;
         scnt  <= scnt_nxt;
         dcnt  <= dcnt_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      scnt_nxt  = scnt;
      dcnt_nxt  = dcnt;
      err_nxt   = err;
      pipe_en   = 1'b0;
      zero_ins  = 1'b0;
      case (state)
         // IDLE accepts its first sample as sample 0, so it shares the RUN rules.
         IDLE, RUN: begin
            pipe_en = valid_i;
            if (valid_i) begin
               state_nxt = RUN;
               if (last_i) begin
                  dcnt_nxt = DW'(DRAIN_CYC);
                  if (scnt == 5'd31) begin
                     state_nxt = DRAIN;
                  end else begin
                     err_nxt[0] = 1'b1;
                     state_nxt  = PAD;
                  end
               end
            end
         end
         PAD: begin
            pipe_en  = 1'b1;
            zero_ins = 1'b1;
            if (valid_i) err_nxt[1] = 1'b1;
            if (scnt == 5'd31) begin
               state_nxt = DRAIN;
               dcnt_nxt  = DW'(DRAIN_CYC);
            end
         end
         DRAIN: begin
            pipe_en  = 1'b1;
            zero_ins = 1'b1;
            if (valid_i) err_nxt[1] = 1'b1;
            dcnt_nxt = dcnt - DW'(1);
            if (dcnt <= DW'(1)) begin
               state_nxt = IDLE;
               dcnt_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (pipe_en) scnt_nxt = scnt + 5'd1;
      // The drain tail keeps scnt running for the stages, but the next stream must start at 0.
      if (state == DRAIN && dcnt <= DW'(1)) scnt_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ocnt    <= '0;
         done_p1 <= 1'b0;
      end else begin
         done_p1 <= out_valid_i && (ocnt == 5'd31);
         if (out_valid_i) ocnt <= ocnt + 5'd1;
      end
   end

`ifdef FFT_SEQ_STATS_EN
   logic [CNT_W-1:0] fcnt;

   always_ff @(posedge clk) begin
      if (rst)          fcnt <= '0;
      else if (done_p1) fcnt <= fcnt + CNT_W'(1);
   end

   assign frame_cnt_o = fcnt;
`else
   assign frame_cnt_o = '0;
`endif

   assign pipe_en_o     = pipe_en;
   assign zero_ins_o    = zero_ins;
   assign state_o       = scnt[4];
   assign wn_idx_o      = scnt[4] ? scnt[3:0] : 4'd0;
   assign frame_start_o = pipe_en && (scnt == 5'd0) && !zero_ins;
   assign frame_done_o  = done_p1;
   assign busy_o        = (state != IDLE);
   assign err_o         = err;

endmodule
